// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin two-port arbiter/sequencer for the 4 x 8-bit register file
// Command fields are latched straight into the RF output registers on grant; read data is captured per owner.
module regfile_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic              input_Clock,
   input  logic              input_Reset,
   input  logic              input_Req0,
   input  logic              input_Req1,
   input  logic              input_Write0,
   input  logic              input_Write1,
   input  logic [ADDR_W-1:0] input_RAddrA0,
   input  logic [ADDR_W-1:0] input_RAddrA1,
   input  logic [ADDR_W-1:0] input_RAddrB0,
   input  logic [ADDR_W-1:0] input_RAddrB1,
   input  logic [ADDR_W-1:0] input_WAddr0,
   input  logic [ADDR_W-1:0] input_WAddr1,
   input  logic [DATA_W-1:0] input_WData0,
   input  logic [DATA_W-1:0] input_WData1,
   output logic              output_Ack0,
   output logic              output_Ack1,
   output logic [DATA_W-1:0] output_RDataA0,
   output logic [DATA_W-1:0] output_RDataA1,
   output logic [DATA_W-1:0] output_RDataB0,
   output logic [DATA_W-1:0] output_RDataB1,
   output logic              output_Busy,
   output logic [1:0]        output_Grant,
   output logic              output_RF_Read_Write,
   output logic [ADDR_W-1:0] output_RF_Read_Register1,
   output logic [ADDR_W-1:0] output_RF_Read_Register2,
   output logic [ADDR_W-1:0] output_RF_Write_Register,
   output logic [DATA_W-1:0] output_RF_Write_Data,
   input  logic [DATA_W-1:0] input_RF_Read_Data1,
   input  logic [DATA_W-1:0] input_RF_Read_Data2
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t              state_q;
   logic                ptr_q;
   logic                owner_q;
   logic                write_q;
   logic                ack0_q, ack1_q;
   logic [DATA_W-1:0]   rdata_a0_q, rdata_b0_q, rdata_a1_q, rdata_b1_q;
   logic                busy_q;
   logic [1:0]          grant_q;
   logic                rf_rw_q;
   logic [ADDR_W-1:0]   rf_ra1_q, rf_ra2_q, rf_wa_q;
   logic [DATA_W-1:0]   rf_wd_q;

   logic                sel_d;
   logic                wr_d;
   logic [ADDR_W-1:0]   ra_d, rb_d, wa_d;
   logic [DATA_W-1:0]   wd_d;

   // ptr_q holds the last granted port, so a tie goes to the other one
   always_comb begin
      sel_d = 1'b0;
      if (input_Req0 && input_Req1) begin
         sel_d = ~ptr_q;
      end else if (input_Req1) begin
         sel_d = 1'b1;
      end
      wr_d = sel_d ? input_Write1  : input_Write0;
      ra_d = sel_d ? input_RAddrA1 : input_RAddrA0;
      rb_d = sel_d ? input_RAddrB1 : input_RAddrB0;
      wa_d = sel_d ? input_WAddr1  : input_WAddr0;
      wd_d = sel_d ? input_WData1  : input_WData0;
   end

   always_ff @(posedge input_Clock or negedge input_Reset) begin
      if (!input_Reset) begin
         state_q    <= IDLE;
         ptr_q      <= 1'b1;
         owner_q    <= 1'b0;
         write_q    <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rdata_a0_q <= '0;
         rdata_b0_q <= '0;
         rdata_a1_q <= '0;
         rdata_b1_q <= '0;
         busy_q     <= 1'b0;
         grant_q    <= 2'b00;
         rf_rw_q    <= 1'b0;
         rf_ra1_q   <= '0;
         rf_ra2_q   <= '0;
         rf_wa_q    <= '0;
         rf_wd_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (input_Req0 || input_Req1) begin
                  owner_q  <= sel_d;
                  write_q  <= wr_d;
                  rf_rw_q  <= wr_d;
                  rf_ra1_q <= ra_d;
                  rf_ra2_q <= rb_d;
                  rf_wa_q  <= wa_d;
                  rf_wd_q  <= wd_d;
                  grant_q  <= sel_d ? 2'b10 : 2'b01;
                  busy_q   <= 1'b1;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               rf_rw_q <= 1'b0;
               if (write_q) begin
                  ack0_q  <= ~owner_q;
                  ack1_q  <= owner_q;
                  state_q <= ACK;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (owner_q) begin
                  rdata_a1_q <= input_RF_Read_Data1;
                  rdata_b1_q <= input_RF_Read_Data2;
                  ack1_q     <= 1'b1;
               end else begin
                  rdata_a0_q <= input_RF_Read_Data1;
                  rdata_b0_q <= input_RF_Read_Data2;
                  ack0_q     <= 1'b1;
               end
               state_q <= ACK;
            end
            ACK: begin
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               ptr_q   <= owner_q;
               grant_q <= 2'b00;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign output_Ack0              = ack0_q;
   assign output_Ack1              = ack1_q;
   assign output_RDataA0           = rdata_a0_q;
   assign output_RDataB0           = rdata_b0_q;
   assign output_RDataA1           = rdata_a1_q;
   assign output_RDataB1           = rdata_b1_q;
   assign output_Busy              = busy_q;
   assign output_Grant             = grant_q;
   assign output_RF_Read_Write     = rf_rw_q;
   assign output_RF_Read_Register1 = rf_ra1_q;
   assign output_RF_Read_Register2 = rf_ra2_q;
   assign output_RF_Write_Register = rf_wa_q;
   assign output_RF_Write_Data     = rf_wd_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed bench for regfile_arbiter with a behavioural register file
module tb_regfile_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
   logic [1:0] raa0 = '0, raa1 = '0, rab0 = '0, rab1 = '0, wa0 = '0, wa1 = '0;
   logic [7:0] wd0 = '0, wd1 = '0;
   logic       ack0, ack1, busy, rf_rw;
   logic [7:0] rda0, rda1, rdb0, rdb1, rf_wd;
   logic [1:0] grant, rf_ra1, rf_ra2, rf_wa;
   logic [7:0] rf_rd1 = '0, rf_rd2 = '0;
   logic [7:0] rf_mem [4] = '{default: 8'h00};

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // register file: registered reads, write on the same edge; contents survive arbiter reset
   always @(posedge clk) begin
      if (rf_rw) rf_mem[rf_wa] <= rf_wd;
      rf_rd1 <= rf_mem[rf_ra1];
      rf_rd2 <= rf_mem[rf_ra2];
   end

   regfile_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
      .input_Clock(clk), .input_Reset(rst_n),
      .input_Req0(req0), .input_Req1(req1),
      .input_Write0(wr0), .input_Write1(wr1),
      .input_RAddrA0(raa0), .input_RAddrA1(raa1),
      .input_RAddrB0(rab0), .input_RAddrB1(rab1),
      .input_WAddr0(wa0), .input_WAddr1(wa1),
      .input_WData0(wd0), .input_WData1(wd1),
      .output_Ack0(ack0), .output_Ack1(ack1),
      .output_RDataA0(rda0), .output_RDataA1(rda1),
      .output_RDataB0(rdb0), .output_RDataB1(rdb1),
      .output_Busy(busy), .output_Grant(grant),
      .output_RF_Read_Write(rf_rw),
      .output_RF_Read_Register1(rf_ra1), .output_RF_Read_Register2(rf_ra2),
      .output_RF_Write_Register(rf_wa), .output_RF_Write_Data(rf_wd),
      .input_RF_Read_Data1(rf_rd1), .input_RF_Read_Data2(rf_rd2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int port, input logic rq, input logic w, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [1:0] wa, input logic [7:0] wd);
      if (port == 0) begin
         req0 = rq; wr0 = w; raa0 = ra; rab0 = rb; wa0 = wa; wd0 = wd;
      end else begin
         req1 = rq; wr1 = w; raa1 = ra; rab1 = rb; wa1 = wa; wd1 = wd;
      end
   endtask

   // called at posedge+1 of an IDLE cycle with no request pending; that cycle is cycle 0
   task automatic run_txn(input int port, input logic w, input logic [1:0] ra, input logic [1:0] rb,
                          input logic [1:0] wa, input logic [7:0] wd, input int exp_lat);
      int cyc = 0;
      logic got = 1'b0;
      logic other = 1'b0;
      logic rw1 = 1'b0;
      logic [1:0] g1 = 2'b00;
      drive(port, 1'b1, w, ra, rb, wa, wd);
      while (!got && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            rw1 = rf_rw;
            g1 = grant;
         end
         if ((port == 0) ? ack1 : ack0) other = 1'b1;
         if ((port == 0) ? ack0 : ack1) got = 1'b1;
      end
      check("txn_ack_seen", 32'(got), 32'd1);
      check("txn_latency", cyc, exp_lat);
      check("txn_issue_rw", 32'(rw1), 32'(w));
      check("txn_issue_grant", 32'(g1), (port == 0) ? 32'd1 : 32'd2);
      check("txn_other_ack", 32'(other), 32'd0);
      drive(port, 1'b0, w, ra, rb, wa, wd);
      @(posedge clk); #1;
      check("txn_ack_pulse", {ack1, ack0}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int last;
      int exp_port;
      int acks;
      logic prev;

      // power-on reset
      repeat (2) @(posedge clk);
      #1;
      check("por_busy", busy, 0);
      check("por_grant", grant, 0);
      check("por_acks", {ack1, ack0}, 0);
      check("por_rf_rw", rf_rw, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // port 0 write 0xA5 -> reg 2, then read A=2 B=0
      run_txn(0, 1'b1, 2'd0, 2'd0, 2'd2, 8'hA5, 2);
      run_txn(0, 1'b0, 2'd2, 2'd0, 2'd0, 8'h00, 3);
      check("rd0_a", rda0, 8'hA5);
      check("rd0_b", rdb0, 8'h00);
      check("rd0_p1a_untouched", rda1, 8'h00);
      check("rd0_p1b_untouched", rdb1, 8'h00);
      check("idle_rf_ra1_hold", rf_ra1, 2'd2);

      // mid-simulation asynchronous reset
      rst_n = 1'b0;
      #1;
      check("rst_rda0", rda0, 0);
      check("rst_rf_ra1", rf_ra1, 0);
      check("rst_rf_wa_wd", {rf_wa, rf_wd}, 0);
      check("rst_busy_grant", {busy, grant}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_idle_busy", busy, 0);
      end

      // simultaneous requests: port 0 write 0x11 -> reg 1, port 1 read reg 1 / reg 2
      drive(0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 8'h11);
      drive(1, 1'b1, 1'b0, 2'd1, 2'd2, 2'd0, 8'h00);
      @(posedge clk); #1;
      check("tie_c1_grant", grant, 2'b01);
      check("tie_c1_rf_rw", rf_rw, 1);
      check("tie_c1_rf_wa_wd", {rf_wa, rf_wd}, {2'd1, 8'h11});
      @(posedge clk); #1;
      check("tie_c2_acks", {ack1, ack0}, 2'b01);
      drive(0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00);
      @(posedge clk); #1;
      check("tie_c3_idle", {busy, grant, ack1, ack0}, 0);
      @(posedge clk); #1;
      check("tie_c4_grant", grant, 2'b10);
      check("tie_c4_rf", {rf_rw, rf_ra1, rf_ra2}, {1'b0, 2'd1, 2'd2});
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("tie_c6_acks", {ack1, ack0}, 2'b10);
      check("tie_c6_rda1", rda1, 8'h11);
      check("tie_c6_rdb1", rdb1, 8'hA5);
      drive(1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00);
      @(posedge clk); #1;

      // both ports hold requests for four transactions each
      drive(0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 8'h5A);
      drive(1, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 8'h00);
      n = 0; last = 0; exp_port = 0; prev = 1'b0;
      for (int c = 1; c <= 80 && n < 8; c++) begin
         @(posedge clk); #1;
         if (prev) begin
            check("b2b_ack_pulse", {ack1, ack0}, 0);
            prev = 1'b0;
         end else if (ack0 || ack1) begin
            check("b2b_ack_port", {ack1, ack0}, (exp_port == 0) ? 2'b01 : 2'b10);
            check("b2b_grant", grant, (exp_port == 0) ? 2'b01 : 2'b10);
            if (n > 0) check("b2b_gap", c - last, (exp_port == 1) ? 4 : 3);
            if (exp_port == 1) check("b2b_rdata1", {rda1, rdb1}, {8'h5A, 8'h11});
            last = c;
            n++;
            exp_port = 1 - exp_port;
            prev = 1'b1;
            if (n == 8) begin
               drive(0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00);
               drive(1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00);
            end
         end
      end
      check("b2b_count", n, 8);
      @(posedge clk); #1;
      check("b2b_final_pulse", {ack1, ack0}, 0);

      // reset during ISSUE of a port 1 write of 0xFF -> reg 3
      drive(1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd3, 8'hFF);
      @(posedge clk); #1;
      check("abort_issue_rw", {rf_rw, rf_wa}, {1'b1, 2'd3});
      rst_n = 1'b0;
      #1;
      check("abort_rw_drop", rf_rw, 0);
      check("abort_busy_grant", {busy, grant}, 0);
      drive(1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      acks = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (ack1) acks++;
      end
      check("abort_no_ack1", acks, 0);
      run_txn(0, 1'b0, 2'd3, 2'd2, 2'd0, 8'h00, 3);
      check("abort_reg3", rda0, 8'h00);
      check("abort_reg2", rdb0, 8'hA5);

      // port 1 read, then port 0 read leaves port 1 data alone
      run_txn(1, 1'b0, 2'd2, 2'd0, 2'd0, 8'h00, 3);
      check("p1_rda1", rda1, 8'hA5);
      check("p1_rdb1", rdb1, 8'h5A);
      run_txn(0, 1'b0, 2'd0, 2'd1, 2'd0, 8'h00, 3);
      check("p0_rda0", rda0, 8'h5A);
      check("p0_rdb0", rdb0, 8'h11);
      check("p0_rda1_hold", rda1, 8'hA5);
      check("p0_rdb1_hold", rdb1, 8'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-port arbiter and sequencer in front of the 4 x 8-bit register file. It accepts read or write transactions from two requesters over level req / pulse ack handshakes and grants them round-robin. It drives the register file's command pins and captures its registered read data into a per-requester holding register. It sits between the control/datapath masters and the register file, which is the only resource it owns.

## Interface
- DATA_W, 8, data width (must match register file)
- ADDR_W, 2, register address width (4 registers)

- input_Clock  in  1  rising-edge clock shared with register file
- input_Reset  in  1  asynchronous, active-low reset
- input_Req0 / input_Req1  in  1  transaction request, level, held until ack
- input_Write0 / input_Write1  in  1  1 = write, 0 = read; stable while Req high
- input_RAddrA0 / input_RAddrA1  in  ADDR_W  first read address
- input_RAddrB0 / input_RAddrB1  in  ADDR_W  second read address
- input_WAddr0 / input_WAddr1  in  ADDR_W  write address
- input_WData0 / input_WData1  in  DATA_W  write data
- output_Ack0 / output_Ack1  out  1  one-cycle completion pulse
- output_RDataA0 / output_RDataA1  out  DATA_W  captured read data A, held until next read by that port
- output_RDataB0 / output_RDataB1  out  DATA_W  captured read data B, same rule
- output_Busy  out  1  1 whenever state is not IDLE
- output_Grant  out  2  one-hot current owner, 00 in IDLE
- output_RF_Read_Write  out  1  register file command, 1 = write
- output_RF_Read_Register1 / output_RF_Read_Register2  out  ADDR_W  register file read addresses
- output_RF_Write_Register  out  ADDR_W  register file write address
- output_RF_Write_Data  out  DATA_W  register file write data
- input_RF_Read_Data1 / input_RF_Read_Data2  in  DATA_W  register file registered read outputs

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any Req is high, choose an owner and latch its Write, addresses and WData into the command register, then go to ISSUE. Otherwise stay.
- Owner selection:
  - only one requesting: it wins.
  - both requesting: the port not granted last wins.
  - Last-granted pointer resets to port 1, so port 0 wins the first tie.
- ISSUE: drive the latched command to the register file.
  - output_RF_Read_Write = latched Write; the register file acts on the ISSUE-exit edge.
  - Next state: WAIT for a read, ACK for a write.
- WAIT: register file read outputs are now valid. On exit, load the owner's RDataA/RDataB from input_RF_Read_Data1/2, then go to ACK.
- ACK: assert the owner's Ack for exactly one cycle, update the last-granted pointer, go to IDLE.
- output_RF_Read_Write is 1 only in ISSUE of a write and 0 in all other states.
- RF address and data outputs carry the latched command in ISSUE, WAIT and ACK, and hold their last value in IDLE.
- The non-owner's RData registers and Ack are never touched.
- A write to register N completes before any later transaction is issued, so a following read of N returns the new value.

## Timing
- Reset (input_Reset low, asynchronous):
  - state becomes IDLE, pointer becomes port 1.
  - All outputs become 0: Acks, RData, Busy, Grant, all RF_* outputs.
  - A transaction in flight is dropped with no Ack. If reset lands in ISSUE, RF_Read_Write falls immediately and no write occurs.
- Read latency: Req sampled high in IDLE at cycle 0 gives ISSUE at 1, WAIT at 2, ACK at 3. Ack is high in cycle 3 and RData is valid from cycle 3.
- Write latency: IDLE at 0, ISSUE at 1, ACK at 2. The register is updated at the end of cycle 1.
- Requester rules:
  - may change Req and fields at the edge ending the Ack cycle.
  - Req still high in the following IDLE cycle means a new transaction.
  - Deasserting Req before Ack is illegal and its behaviour is undefined.
- Back-to-back: with both ports requesting continuously, grants alternate 0,1,0,1. A read takes 4 cycles per transaction including IDLE; a write takes 3.
- Req arriving while Busy is ignored until IDLE.

## Test plan
- Reset: drive input_Reset low mid-simulation → all outputs 0 and Grant = 00 the same cycle. After release with no Req, Busy stays 0.
- Port 0 writes 0xA5 to reg 2, then reads A = 2, B = 0 → write Ack at cycle 2. Read Ack 3 cycles after its IDLE sample, with RDataA0 = 0xA5, RDataB0 = 0x00. Port 1 RData unchanged.
- Both ports raise Req in the same cycle after reset (port 0 write 0x11 to reg 1, port 1 read reg 1) → port 0 granted first. Port 1's read then returns 0x11 and Grant = 01, then 10.
- Both ports hold Req for four transactions each → grants strictly alternate and each Ack is a single-cycle pulse on the correct port only.
- Assert reset during ISSUE of a port 1 write of 0xFF to reg 3 → no Ack1. A subsequent read of reg 3 returns 0x00.
- Port 0 reads reg 0/1 while port 1 idles → output_RDataA1/B1 hold their previous values and output_Ack1 stays 0.
